// File: rtl/vec16_checker_pkg.sv
// Shared encodings for the 16-bit logic-chip response checker.
// Stimulus sources import the same op and state codes.
package vec16_checker_pkg;

    typedef enum logic [1:0] {
        OP_NOT = 2'd0,
        OP_BUF = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/vec16_checker_expect.sv
// Golden model: expected result of one 16-bit logic operation.
// Purely combinational so benches can reuse it directly.
module vec16_expect
    import vec16_checker_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] exp
);

    // Select the reference function; b only matters for AND/OR.
    always_comb begin
        exp = '0;
        unique case (op)
            OP_NOT:  exp = ~a;
            OP_BUF:  exp = a;
            OP_AND:  exp = a & b;
            OP_OR:   exp = a | b;
            default: exp = '0;
        endcase
    end

endmodule

// File: rtl/vec16_checker.sv
// Streams (operand, result) pairs, compares against the golden model,
// counts passes/fails and latches the first mismatch.
module vec16_checker
    import vec16_checker_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [WIDTH-1:0] vec_a,
    input  logic [WIDTH-1:0] vec_b,
    input  logic [WIDTH-1:0] dut_out,
    input  logic             vec_last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_exp,
    output logic [WIDTH-1:0] first_fail_got,
    output logic             any_fail
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q;
    state_e           state_d;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] idx_q;
    logic [WIDTH-1:0] exp;
    logic             start_ok;
    logic             xfer;
    logic             match;

    // busy and ready come straight off the state register.
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign vec_ready = busy;
    assign start_ok  = start && !busy;
    assign xfer      = vec_valid && busy;
    assign match     = (dut_out == exp);

    vec16_expect #(.WIDTH(WIDTH)) u_expect (
        .op  (op_q),
        .a   (vec_a),
        .b   (vec_b),
        .exp (exp)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: start arms a run, a last transfer ends it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start)           state_d = ST_RUN;
            ST_RUN:  if (xfer && vec_last) state_d = ST_DONE;
            ST_DONE: if (start)           state_d = ST_RUN;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Counters and first-mismatch capture; all saturate at CNT_MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q           <= '0;
            idx_q          <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
            any_fail       <= 1'b0;
        end else if (start_ok) begin
            op_q           <= op;
            idx_q          <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
            any_fail       <= 1'b0;
        end else if (xfer) begin
            if (match) begin
                if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
                if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
                if (!any_fail) begin
                    first_fail_idx <= idx_q;
                    first_fail_exp <= exp;
                    first_fail_got <= dut_out;
                    any_fail       <= 1'b1;
                end
            end
            if (idx_q != CNT_MAX) idx_q <= idx_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vec16_checker.sv
// Directed bench for vec16_checker, built with 4-bit counters
// so saturation is reachable with a short stream.
module tb_vec16_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        vec_valid;
    logic        vec_ready;
    logic [15:0] vec_a;
    logic [15:0] vec_b;
    logic [15:0] dut_out;
    logic        vec_last;
    logic        busy;
    logic        done;
    logic [3:0]  pass_cnt;
    logic [3:0]  fail_cnt;
    logic [3:0]  first_fail_idx;
    logic [15:0] first_fail_exp;
    logic [15:0] first_fail_got;
    logic        any_fail;

    int n_tests = 0;
    int n_fail  = 0;

    vec16_checker #(.WIDTH(16), .CNT_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .op             (op),
        .vec_valid      (vec_valid),
        .vec_ready      (vec_ready),
        .vec_a          (vec_a),
        .vec_b          (vec_b),
        .dut_out        (dut_out),
        .vec_last       (vec_last),
        .busy           (busy),
        .done           (done),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .first_fail_idx (first_fail_idx),
        .first_fail_exp (first_fail_exp),
        .first_fail_got (first_fail_got),
        .any_fail       (any_fail)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        bit          start;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] got;
        bit          last;
        int          pass;
        int          fail;
        int          ff_idx;
        logic [15:0] ff_exp;
        logic [15:0] ff_got;
    } rec_t;

    rec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " vec_ready"}, 32'(vec_ready), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " pass_cnt"}, 32'(pass_cnt), 0);
        chk({tag, " fail_cnt"}, 32'(fail_cnt), 0);
        chk({tag, " ff_idx"}, 32'(first_fail_idx), 0);
        chk({tag, " ff_exp"}, 32'(first_fail_exp), 0);
        chk({tag, " ff_got"}, 32'(first_fail_got), 0);
        chk({tag, " any_fail"}, 32'(any_fail), 0);
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic do_start(input logic [1:0] o);
        start = 1'b1;
        op    = o;
        @(negedge clk);
        start = 1'b0;
        op    = o ^ 2'b11;
    endtask

    // Called at a negedge; returns one negedge after the transfer edge.
    task automatic xfer(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] got, input bit last);
        vec_valid = 1'b1;
        vec_a     = a;
        vec_b     = b;
        dut_out   = got;
        vec_last  = last;
        @(negedge clk);
        vec_valid = 1'b0;
        vec_last  = 1'b0;
    endtask

    initial begin
        int  ep;
        int  ef;
        bit  in_run;
        rec_t r;

        tbl[0]  = '{1, 2'd0, 16'h0000, 16'h0000, 16'hFFFF, 0, 1, 0, 0, 16'h0, 16'h0};
        tbl[1]  = '{0, 2'd0, 16'hFFFF, 16'h0000, 16'h0000, 0, 2, 0, 0, 16'h0, 16'h0};
        tbl[2]  = '{0, 2'd0, 16'hAAAA, 16'h0000, 16'h5555, 0, 3, 0, 0, 16'h0, 16'h0};
        tbl[3]  = '{0, 2'd0, 16'h3CC3, 16'h0000, 16'hC33C, 0, 4, 0, 0, 16'h0, 16'h0};
        tbl[4]  = '{0, 2'd0, 16'h1234, 16'h0000, 16'hEDCB, 1, 5, 0, 0, 16'h0, 16'h0};
        tbl[5]  = '{1, 2'd0, 16'h0000, 16'h0000, 16'hFFFF, 0, 1, 0, 0, 16'h0, 16'h0};
        tbl[6]  = '{0, 2'd0, 16'hFFFF, 16'h0000, 16'h0000, 0, 2, 0, 0, 16'h0, 16'h0};
        tbl[7]  = '{0, 2'd0, 16'hAAAA, 16'h0000, 16'hAAAA, 0, 2, 1, 0, 16'h0, 16'h0};
        tbl[8]  = '{0, 2'd0, 16'h3CC3, 16'h0000, 16'hC33C, 0, 3, 1, 0, 16'h0, 16'h0};
        tbl[9]  = '{0, 2'd0, 16'h1234, 16'h0000, 16'h1234, 1, 3, 2,
                    2, 16'h5555, 16'hAAAA};
        tbl[10] = '{1, 2'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 0, 1, 0, 0, 16'h0, 16'h0};
        tbl[11] = '{1, 2'd3, 16'hFFFF, 16'h00FF, 16'h00FF, 1, 2, 0, 0, 16'h0, 16'h0};
        tbl[12] = '{1, 2'd3, 16'hF0F0, 16'h3C3C, 16'hFCFC, 1, 1, 0, 0, 16'h0, 16'h0};
        tbl[13] = '{1, 2'd1, 16'h1234, 16'h0000, 16'h1234, 0, 1, 0, 0, 16'h0, 16'h0};
        tbl[14] = '{0, 2'd1, 16'hABCD, 16'hFFFF, 16'hABCD, 0, 2, 0, 0, 16'h0, 16'h0};
        tbl[15] = '{0, 2'd1, 16'h0F0F, 16'h0000, 16'h0F0E, 1, 2, 1,
                    2, 16'h0F0F, 16'h0F0E};

        reset     = 1'b1;
        start     = 1'b0;
        op        = 2'd0;
        vec_valid = 1'b1;
        vec_last  = 1'b1;
        vec_a     = 16'h1111;
        vec_b     = 16'h2222;
        dut_out   = 16'h3333;

        // Reset held with a vector offered: nothing moves.
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("idle valid");
        vec_valid = 1'b0;
        vec_last  = 1'b0;
        @(negedge clk);

        // Table-driven runs.
        ep     = 0;
        ef     = 0;
        in_run = 0;
        for (int i = 0; i < 16; i++) begin
            r = tbl[i];
            if (r.start) begin
                do_start(r.op);
                if (!in_run) begin
                    ep = 0;
                    ef = 0;
                    chk($sformatf("v%0d start any_fail", i), 32'(any_fail), 0);
                end
                chk($sformatf("v%0d start busy", i), 32'(busy), 1);
                chk($sformatf("v%0d start ready", i), 32'(vec_ready), 1);
                chk($sformatf("v%0d start done", i), 32'(done), 0);
                chk($sformatf("v%0d start pass", i), 32'(pass_cnt), 32'(ep));
                chk($sformatf("v%0d start fail", i), 32'(fail_cnt), 32'(ef));
                in_run = 1;
            end
            xfer(r.a, r.b, r.got, r.last);
            chk($sformatf("v%0d pass_cnt", i), 32'(pass_cnt), 32'(r.pass));
            chk($sformatf("v%0d fail_cnt", i), 32'(fail_cnt), 32'(r.fail));
            ep = r.pass;
            ef = r.fail;
            if (r.last) begin
                in_run = 0;
                chk($sformatf("v%0d done", i), 32'(done), 1);
                chk($sformatf("v%0d busy", i), 32'(busy), 0);
                chk($sformatf("v%0d ready", i), 32'(vec_ready), 0);
                chk($sformatf("v%0d any_fail", i), 32'(any_fail),
                    32'(r.fail != 0));
                chk($sformatf("v%0d ff_idx", i), 32'(first_fail_idx),
                    32'(r.ff_idx));
                chk($sformatf("v%0d ff_exp", i), 32'(first_fail_exp),
                    32'(r.ff_exp));
                chk($sformatf("v%0d ff_got", i), 32'(first_fail_got),
                    32'(r.ff_got));
            end
        end

        // Saturation with random stalls; idle cycles carry vec_last.
        do_start(2'd1);
        for (int i = 0; i < 20; i++) begin
            logic [15:0] a;
            int          g;
            a = 16'(i * 16'h0123);
            xfer(a, 16'($urandom), a, 0);
            chk($sformatf("sat%0d pass_cnt", i), 32'(pass_cnt),
                32'((i + 1 > 15) ? 15 : i + 1));
            g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) begin
                vec_last = 1'b1;
                @(negedge clk);
                vec_last = 1'b0;
            end
        end
        chk("sat busy", 32'(busy), 1);
        chk("sat fail_cnt", 32'(fail_cnt), 0);
        xfer(16'hBEEF, 16'h0000, 16'hBEEE, 1);
        chk("sat done", 32'(done), 1);
        chk("sat busy end", 32'(busy), 0);
        chk("sat pass_cnt end", 32'(pass_cnt), 15);
        chk("sat fail_cnt end", 32'(fail_cnt), 1);
        chk("sat ff_idx", 32'(first_fail_idx), 15);
        chk("sat ff_exp", 32'(first_fail_exp), 32'h0000BEEF);
        chk("sat ff_got", 32'(first_fail_got), 32'h0000BEEE);

        // Vectors offered in DONE are ignored.
        vec_valid = 1'b1;
        vec_last  = 1'b1;
        dut_out   = 16'h0000;
        vec_a     = 16'h0000;
        repeat (3) @(negedge clk);
        vec_valid = 1'b0;
        vec_last  = 1'b0;
        chk("done hold", 32'(done), 1);
        chk("done hold pass", 32'(pass_cnt), 15);
        chk("done hold fail", 32'(fail_cnt), 1);

        // Reset in the middle of a run clears outputs before any edge.
        do_start(2'd0);
        xfer(16'h0001, 16'h0, 16'hFFFE, 0);
        xfer(16'h0002, 16'h0, 16'hFFFD, 0);
        xfer(16'h0004, 16'h0, 16'h0004, 0);
        chk("mid pass_cnt", 32'(pass_cnt), 2);
        chk("mid fail_cnt", 32'(fail_cnt), 1);
        #1 reset = 1'b1;
        #1 chk_zero("async reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_zero("post reset");
        do_start(2'd0);
        xfer(16'h00FF, 16'h0, 16'hFF00, 1);
        chk("fresh pass_cnt", 32'(pass_cnt), 1);
        chk("fresh fail_cnt", 32'(fail_cnt), 0);
        chk("fresh done", 32'(done), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vec16_checker.md
Name: vec16_checker

Overview:
Response-side companion to the gate-level stimulus benches for the 16-bit logic chips. A stimulus source streams (operand, DUT result) pairs into this block. It recomputes the expected 16-bit result for the selected operation, compares it with the DUT result, counts passes and fails, and latches the first mismatch. It sits beside the chip under test in self-checking benches and FPGA bring-up harnesses, replacing manual reading of printed tables.

Parameters:
WIDTH, 16, data width of operands and results
CNT_W, 8, width of the pass and fail counters (saturating)

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; captures op, clears results, enters RUN
op  input  2  operation: 0 = NOT a, 1 = BUF a, 2 = AND a,b, 3 = OR a,b; sampled only on an accepted start
vec_valid  input  1  source has a vector on vec_a/vec_b/dut_out
vec_ready  output  1  checker accepts a vector this cycle
vec_a  input  WIDTH  operand a, the value driven to the DUT
vec_b  input  WIDTH  operand b; ignored for op 0 and op 1
dut_out  input  WIDTH  result produced by the DUT for this vector
vec_last  input  1  marks the final vector of the run; qualified by the transfer
busy  output  1  high in RUN
done  output  1  high in DONE
pass_cnt  output  CNT_W  number of matching vectors
fail_cnt  output  CNT_W  number of mismatching vectors
first_fail_idx  output  CNT_W  0-based index of the first mismatch
first_fail_exp  output  WIDTH  expected value at the first mismatch
first_fail_got  output  WIDTH  dut_out value at the first mismatch
any_fail  output  1  sticky flag; set on the first mismatch

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. While reset is high, the state is IDLE and every output and register is 0, including vec_ready, busy, done, counters, index, captured values and any_fail.
- States: IDLE, RUN, DONE.
  - IDLE: start goes to RUN.
  - RUN: a transfer with vec_last = 1 goes to DONE.
  - DONE: start goes to RUN. Otherwise DONE holds indefinitely.
- Accepted start (in IDLE or DONE): next edge latches op, clears pass_cnt, fail_cnt, the vector index, the first_fail_* registers and any_fail, and sets busy.
- start while in RUN is ignored. It does not clear or abort the run.
- Handshake: vec_ready equals busy and is a registered output. A transfer occurs when vec_valid && vec_ready on a rising edge. There is no backpressure other than state. Back-to-back transfers are allowed every cycle.
- Expected value, combinational from the latched op: NOT gives ~vec_a, BUF gives vec_a, AND gives vec_a & vec_b, OR gives vec_a | vec_b. The comparison is a full WIDTH-bit equality.
- Update latency: on a transfer edge, exactly one of pass_cnt or fail_cnt increments, and the index increments. All updated outputs are visible one cycle after the transfer.
- First mismatch: on a mismatch while any_fail = 0, capture the index, expected value and dut_out, and set any_fail. Later mismatches only increment fail_cnt.
- Saturation: pass_cnt and fail_cnt saturate at 2^CNT_W - 1. The index also saturates and does not wrap.
- vec_last transfer: the final vector is counted on the same edge. busy falls and done rises in the cycle after that edge, with final counts already valid.
- vec_valid or vec_last outside RUN: ignored, with no state change.
- Reset mid-run: immediate return to IDLE with all outputs 0. Partial results are lost.

Decomposition:
- Shared package or header: op encodings (OP_NOT, OP_BUF, OP_AND, OP_OR) and state encodings (ST_IDLE, ST_RUN, ST_DONE). Both are reused by the stimulus sources.
- Sub-module: one combinational sub-module, vec16_expect (op, a, b -> exp), so benches can reuse the golden model.
- Everything else, the FSM, counters and capture logic, stays in vec16_checker.

Test Plan:
- Reset and idle: reset pulse with vec_valid = 1 held → all outputs 0; vec_ready = 0 throughout.
- Clean NOT run: op = 0; send pairs (0x0000, 0xFFFF), (0xFFFF, 0x0000), (0xAAAA, 0x5555), (0x3CC3, 0xC33C), and (0x1234, 0xEDCB) with vec_last on the fifth → done = 1 the next cycle, pass_cnt = 5, fail_cnt = 0, any_fail = 0.
- First-fail capture: op = 0; index 2 sends got = 0xAAAA and index 4 sends got = 0x1234, all others correct → fail_cnt = 2, pass_cnt = 3, first_fail_idx = 2, first_fail_exp = 0x5555, first_fail_got = 0xAAAA.
- AND/OR and ignored start: op = 2, a = 0xF0F0, b = 0x3C3C, got = 0x3030 → pass. A start pulse mid-run → no clear, and op stays 2. Restart with op = 3 and got = 0xFCFC → pass, with counters cleared by the restart.
- Stalls and saturation: with CNT_W = 4, send 20 matching vectors with random vec_valid gaps → pass_cnt = 15 and the index holds at 15. done rises exactly 1 cycle after the last transfer.
- Reset mid-run: assert reset after 3 transfers → outputs 0 asynchronously, before the next clk edge. The state returns to IDLE, and a new start begins a fresh run with counts from 0.
